// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory access controller.
// The ADDR_W/DATA_W defaults are the same values the DAG uses.
package dm_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      ACC  = 2'b01,
      DONE = 2'b10
   } dm_state_e;

   localparam int DM_CNT_W  = 4;
   localparam int DM_ADDR_W = 16;
   localparam int DM_DATA_W = 16;

endpackage : dm_pkg

// File: rtl/dm_access_ctrl.sv
// Data-memory access controller. It serialises DM reads and writes against a strobed memory
// and stalls the sequencer while an access is in flight.
module dm_access_ctrl
   import dm_pkg::*;
#(
   parameter int ADDR_W  = DM_ADDR_W,
   parameter int DATA_W  = DM_DATA_W,
   parameter int WAIT_ST = 2
) (
   input  logic              clk_rf,
   input  logic              rst_n,
   input  logic              ps_dm_en,
   input  logic              ps_dm_wrt,
   input  logic [ADDR_W-1:0] dg_dm_add,
   input  logic [DATA_W-1:0] bc_dt,
   input  logic [DATA_W-1:0] mem_dm_rdt,
   output logic              dm_ps_stall,
   output logic              dm_mem_cs,
   output logic              dm_mem_we,
   output logic [ADDR_W-1:0] dm_mem_add,
   output logic [DATA_W-1:0] dm_mem_wdt,
   output logic [DATA_W-1:0] dm_bc_dt,
   output logic              dm_rd_vld,
   output logic              dm_ovr
);

   if (WAIT_ST < 0 || WAIT_ST > 15) begin : g_bad_wait_st
      $error("dm_access_ctrl: WAIT_ST must be in 0..15");
   end

   localparam logic [DM_CNT_W-1:0] WAIT_CNT = DM_CNT_W'(WAIT_ST);

   dm_state_e           state_q, state_d;
   logic [DM_CNT_W-1:0] cnt_q, cnt_d;
   logic [ADDR_W-1:0]   add_q, add_d;
   logic [DATA_W-1:0]   wdt_q, wdt_d;
   logic                wrt_q, wrt_d;
   logic [DATA_W-1:0]   rdt_q, rdt_d;
   logic                ovr_q, ovr_d;

   always_ff @(posedge clk_rf or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         add_q   <= '0;
         wdt_q   <= '0;
         wrt_q   <= 1'b0;
         rdt_q   <= '0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         add_q   <= add_d;
         wdt_q   <= wdt_d;
         wrt_q   <= wrt_d;
         rdt_q   <= rdt_d;
         ovr_q   <= ovr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      add_d   = add_q;
      wdt_d   = wdt_q;
      wrt_d   = wrt_q;
      rdt_d   = rdt_q;
      ovr_d   = ovr_q;
      case (state_q)
         IDLE, DONE: begin
            // DONE accepts a request just like IDLE, giving one access per WAIT_ST+2 cycles
            if (ps_dm_en) begin
               add_d   = dg_dm_add;
               wdt_d   = bc_dt;
               wrt_d   = ps_dm_wrt;
               cnt_d   = WAIT_CNT;
               state_d = ACC;
            end else begin
               state_d = IDLE;
            end
         end
         ACC: begin
            // A request arriving mid-access is dropped; only the sticky flag records it
            if (ps_dm_en) begin
               ovr_d = 1'b1;
            end
            if (cnt_q != '0) begin
               cnt_d = cnt_q - DM_CNT_W'(1);
            end else begin
               if (!wrt_q) begin
                  rdt_d = mem_dm_rdt;
               end
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Moore outputs: the memory strobe and stall are pure decodes of the state register,
   // so an asynchronous reset drops them without waiting for a clock edge.
   assign dm_mem_cs   = (state_q == ACC);
   assign dm_mem_we   = (state_q == ACC) && wrt_q;
   assign dm_ps_stall = (state_q == ACC);
   assign dm_mem_add  = add_q;
   assign dm_mem_wdt  = wdt_q;
   assign dm_bc_dt    = rdt_q;
   assign dm_rd_vld   = (state_q == DONE) && !wrt_q;
   assign dm_ovr      = ovr_q;

endmodule : dm_access_ctrl

// File: tb/tb_dm_access_ctrl.sv
// Directed bench for dm_access_ctrl: one instance with WAIT_ST=2, one with WAIT_ST=0,
// each in front of a small behavioural memory.
module tb_dm_access_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int vec_cnt = 0;
   int err_cnt = 0;

   // ---------------- instance A: WAIT_ST = 2 ----------------
   logic        a_rst_n, a_en, a_wrt;
   logic [15:0] a_add, a_bdt, a_rdt;
   logic        a_stall, a_cs, a_we, a_vld, a_ovr;
   logic [15:0] a_madd, a_wdt, a_bc;

   dm_access_ctrl #(.ADDR_W(16), .DATA_W(16), .WAIT_ST(2)) u_dut_a (
      .clk_rf(clk), .rst_n(a_rst_n), .ps_dm_en(a_en), .ps_dm_wrt(a_wrt),
      .dg_dm_add(a_add), .bc_dt(a_bdt), .mem_dm_rdt(a_rdt),
      .dm_ps_stall(a_stall), .dm_mem_cs(a_cs), .dm_mem_we(a_we),
      .dm_mem_add(a_madd), .dm_mem_wdt(a_wdt), .dm_bc_dt(a_bc),
      .dm_rd_vld(a_vld), .dm_ovr(a_ovr)
   );

   // ---------------- instance B: WAIT_ST = 0 ----------------
   logic        b_rst_n, b_en, b_wrt;
   logic [15:0] b_add, b_bdt, b_rdt;
   logic        b_stall, b_cs, b_we, b_vld, b_ovr;
   logic [15:0] b_madd, b_wdt, b_bc;

   dm_access_ctrl #(.ADDR_W(16), .DATA_W(16), .WAIT_ST(0)) u_dut_b (
      .clk_rf(clk), .rst_n(b_rst_n), .ps_dm_en(b_en), .ps_dm_wrt(b_wrt),
      .dg_dm_add(b_add), .bc_dt(b_bdt), .mem_dm_rdt(b_rdt),
      .dm_ps_stall(b_stall), .dm_mem_cs(b_cs), .dm_mem_we(b_we),
      .dm_mem_add(b_madd), .dm_mem_wdt(b_wdt), .dm_bc_dt(b_bc),
      .dm_rd_vld(b_vld), .dm_ovr(b_ovr)
   );

   // Memory models: unwritten locations read as {8'hA0, addr[7:0]}.
   logic [15:0]  mem_a [0:255];
   logic [255:0] wv_a = '0;
   int           ff_strobes = 0;
   always @(posedge clk) begin
      if (a_cs && a_we) begin
         mem_a[a_madd[7:0]] <= a_wdt;
         wv_a[a_madd[7:0]]  <= 1'b1;
      end
      if (a_cs && a_madd == 16'h00FF) ff_strobes <= ff_strobes + 1;
   end
   assign a_rdt = wv_a[a_madd[7:0]] ? mem_a[a_madd[7:0]] : {8'hA0, a_madd[7:0]};

   logic [15:0]  mem_b [0:255];
   logic [255:0] wv_b = '0;
   always @(posedge clk) begin
      if (b_cs && b_we) begin
         mem_b[b_madd[7:0]] <= b_wdt;
         wv_b[b_madd[7:0]]  <= 1'b1;
      end
   end
   assign b_rdt = wv_b[b_madd[7:0]] ? mem_b[b_madd[7:0]] : {8'hA0, b_madd[7:0]};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec_cnt++;
      assert (obs === exp) else begin
         err_cnt++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic a_req(input logic wrt, input logic [15:0] add, input logic [15:0] dat);
      a_en = 1'b1; a_wrt = wrt; a_add = add; a_bdt = dat;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      a_rst_n = 1'b0; a_en = 1'b0; a_wrt = 1'b0; a_add = '0; a_bdt = '0;
      b_rst_n = 1'b0; b_en = 1'b0; b_wrt = 1'b0; b_add = '0; b_bdt = '0;
      #1;
      chk("rst_cs", a_cs, 0);
      chk("rst_we", a_we, 0);
      chk("rst_stall", a_stall, 0);
      chk("rst_add", a_madd, 0);
      chk("rst_wdt", a_wdt, 0);
      chk("rst_bc", a_bc, 0);
      chk("rst_vld", a_vld, 0);
      chk("rst_ovr", a_ovr, 0);
      tick();
      tick();
      chk("rst_hold_cs", a_cs, 0);

      // write 0x1234 -> 0x0040, requested in the first cycle after reset release
      a_rst_n = 1'b1; b_rst_n = 1'b1;
      a_req(1'b1, 16'h0040, 16'h1234);
      tick();
      chk("wr_c1_cs", a_cs, 1);
      chk("wr_c1_we", a_we, 1);
      chk("wr_c1_stall", a_stall, 1);
      chk("wr_c1_add", a_madd, 16'h0040);
      chk("wr_c1_wdt", a_wdt, 16'h1234);
      a_en = 1'b0;
      tick();
      chk("wr_c2_cs", a_cs, 1);
      chk("wr_c2_we", a_we, 1);
      chk("wr_c2_stall", a_stall, 1);
      tick();
      chk("wr_c3_cs", a_cs, 1);
      chk("wr_c3_stall", a_stall, 1);
      tick();
      chk("wr_done_cs", a_cs, 0);
      chk("wr_done_we", a_we, 0);
      chk("wr_done_stall", a_stall, 0);
      chk("wr_done_vld", a_vld, 0);
      chk("wr_done_add_hold", a_madd, 16'h0040);

      // read back 0x0040, issued from DONE
      a_req(1'b0, 16'h0040, 16'h0000);
      tick();
      chk("rd_c1_cs", a_cs, 1);
      chk("rd_c1_we", a_we, 0);
      chk("rd_c1_stall", a_stall, 1);
      a_en = 1'b0;
      tick();
      tick();
      chk("rd_c3_vld", a_vld, 0);
      tick();
      chk("rd_c4_bc", a_bc, 16'h1234);
      chk("rd_c4_vld", a_vld, 1);
      chk("rd_c4_stall", a_stall, 0);
      tick();
      chk("rd_idle_vld", a_vld, 0);
      chk("rd_idle_bc", a_bc, 16'h1234);

      // overrun: second request to 0x00FF while reading 0x0010
      a_req(1'b0, 16'h0010, 16'h0000);
      tick();
      chk("ovr_c1_ovr", a_ovr, 0);
      a_req(1'b1, 16'h00FF, 16'hDEAD);
      tick();
      chk("ovr_c2_ovr", a_ovr, 1);
      chk("ovr_c2_add", a_madd, 16'h0010);
      chk("ovr_c2_we", a_we, 0);
      chk("ovr_c2_cs", a_cs, 1);
      a_en = 1'b0;
      tick();
      chk("ovr_c3_cs", a_cs, 1);
      tick();
      chk("ovr_done_bc", a_bc, 16'hA010);
      chk("ovr_done_vld", a_vld, 1);
      tick();
      chk("ovr_idle_cs", a_cs, 0);
      chk("ovr_sticky", a_ovr, 1);
      chk("ovr_ff_strobes", ff_strobes, 0);
      chk("ovr_ff_unwritten", wv_a[255], 0);

      // write 0xBEEF, read it, then write 0x5555 elsewhere
      a_req(1'b1, 16'h0020, 16'hBEEF);
      tick();
      a_en = 1'b0;
      tick();
      tick();
      tick();
      a_req(1'b0, 16'h0020, 16'h0000);
      tick();
      a_en = 1'b0;
      tick();
      tick();
      tick();
      chk("beef_bc", a_bc, 16'hBEEF);
      chk("beef_vld", a_vld, 1);
      a_req(1'b1, 16'h0030, 16'h5555);
      tick();
      chk("w55_c1_bc", a_bc, 16'hBEEF);
      chk("w55_c1_we", a_we, 1);
      chk("w55_c1_vld", a_vld, 0);
      a_en = 1'b0;
      tick();
      tick();
      chk("w55_c3_bc", a_bc, 16'hBEEF);
      tick();
      chk("w55_done_vld", a_vld, 0);
      chk("w55_done_bc", a_bc, 16'hBEEF);
      tick();
      chk("w55_mem", mem_a[8'h30], 16'h5555);
      chk("w55_ovr_sticky", a_ovr, 1);

      // reset in the middle of a read's ACC
      a_req(1'b0, 16'h0020, 16'h0000);
      tick();
      a_en = 1'b0;
      tick();
      chk("arst_pre_cs", a_cs, 1);
      #2;
      a_rst_n = 1'b0;
      #1;
      chk("arst_cs", a_cs, 0);
      chk("arst_we", a_we, 0);
      chk("arst_stall", a_stall, 0);
      chk("arst_bc", a_bc, 0);
      chk("arst_ovr", a_ovr, 0);
      chk("arst_vld", a_vld, 0);
      tick();
      chk("arst_hold_vld", a_vld, 0);
      a_rst_n = 1'b1;
      tick();
      chk("arst_post1_vld", a_vld, 0);
      chk("arst_post1_cs", a_cs, 0);
      tick();
      chk("arst_post2_vld", a_vld, 0);
      chk("arst_post2_bc", a_bc, 0);

      // WAIT_ST = 0: back-to-back reads of 0x0001 and 0x0002
      b_en = 1'b1; b_wrt = 1'b0; b_add = 16'h0001;
      tick();
      chk("b_c1_cs", b_cs, 1);
      chk("b_c1_stall", b_stall, 1);
      chk("b_c1_add", b_madd, 16'h0001);
      b_en = 1'b0;
      tick();
      chk("b_done1_vld", b_vld, 1);
      chk("b_done1_bc", b_bc, 16'hA001);
      chk("b_done1_cs", b_cs, 0);
      chk("b_done1_stall", b_stall, 0);
      b_en = 1'b1; b_add = 16'h0002;
      tick();
      chk("b_c3_cs", b_cs, 1);
      chk("b_c3_vld", b_vld, 0);
      chk("b_c3_add", b_madd, 16'h0002);
      b_en = 1'b0;
      tick();
      chk("b_done2_vld", b_vld, 1);
      chk("b_done2_bc", b_bc, 16'hA002);
      tick();
      chk("b_idle_vld", b_vld, 0);
      chk("b_ovr", b_ovr, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule : tb_dm_access_ctrl
